// File: rtl/tipi_pkg.sv
// Shared constants for the TIPI Pi/TI register paths.
// Holds TI latch addresses, frame lengths and the RD/RC select encoding.
package tipi_pkg;

  localparam logic [15:0] ADDR_WD = 16'h5FFF;
  localparam logic [15:0] ADDR_WC = 16'h5FFD;
  localparam logic [15:0] ADDR_RD = 16'h5FFB;
  localparam logic [15:0] ADDR_RC = 16'h5FF9;

  localparam logic [3:0] FRAME_LEN_PLAIN  = 4'd8;
  localparam logic [3:0] FRAME_LEN_PARITY = 4'd9;

  typedef enum logic {
    SEL_RD = 1'b0,
    SEL_RC = 1'b1
  } sel_e;

endpackage

// File: rtl/tipi_sync.sv
// Multi-flop synchroniser for one asynchronous bit with a rise detector.
// Ports: clk, rst (sync, high), d (async in), q (synced level), rise (1-cycle pulse).
module tipi_sync #(
  parameter int STAGES  = 2,
  parameter bit RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q,
  output logic rise
);

  logic [STAGES-1:0] sr;
  logic              prev;

  always_ff @(posedge clk) begin
    if (rst) begin
      sr   <= {STAGES{RST_VAL}};
      prev <= RST_VAL;
    end else begin
      sr   <= {sr[STAGES-2:0], d};
      prev <= sr[STAGES-1];
    end
  end

  assign q    = sr[STAGES-1];
  assign rise = q & ~prev;

endmodule

// File: rtl/tipi_pi_read_path.sv
// Pi-to-TI return path: deserialises Pi frames into RD/RC, serves TI reads.
// Ports: clk/rst, Pi serial (pi_sclk, pi_sdata, pi_latch, pi_sel),
// TI bus (ti_a, ti_memen, ti_dbin, ti_data_out, ti_data_oe),
// debug (rd_q, rc_q, frame_err). Option macro: TIPI_SHIFT_PARITY_EN.
module tipi_pi_read_path
  import tipi_pkg::*;
#(
  parameter int          SYNC_STAGES = 2,
  parameter logic [15:0] RD_ADDR     = ADDR_RD,
  parameter logic [15:0] RC_ADDR     = ADDR_RC
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pi_sclk,
  input  logic        pi_sdata,
  input  logic        pi_latch,
  input  logic        pi_sel,
  input  logic [0:15] ti_a,
  input  logic        ti_memen,
  input  logic        ti_dbin,
  output logic [7:0]  ti_data_out,
  output logic        ti_data_oe,
  output logic [7:0]  rd_q,
  output logic [7:0]  rc_q,
  output logic        frame_err
);

`ifdef TIPI_SHIFT_PARITY_EN
  localparam int         SHIFT_W   = 9;
  localparam logic [3:0] FRAME_LEN = FRAME_LEN_PARITY;
`else
  localparam int         SHIFT_W   = 8;
  localparam logic [3:0] FRAME_LEN = FRAME_LEN_PLAIN;
`endif

  logic sclk_q, sclk_rise;
  logic latch_q, latch_rise;
  logic memen_s, unused_memen_rise;
  logic dbin_s, unused_dbin_rise;

  tipi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk (
    .clk(clk), .rst(rst), .d(pi_sclk), .q(sclk_q), .rise(sclk_rise)
  );
  tipi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_latch (
    .clk(clk), .rst(rst), .d(pi_latch), .q(latch_q), .rise(latch_rise)
  );
  tipi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_memen (
    .clk(clk), .rst(rst), .d(ti_memen), .q(memen_s),
    .rise(unused_memen_rise)
  );
  tipi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_dbin (
    .clk(clk), .rst(rst), .d(ti_dbin), .q(dbin_s),
    .rise(unused_dbin_rise)
  );

  // Level-only synchronisers; same depth keeps them aligned to the strobes.
  logic [17:0]                   plain_d;
  logic [SYNC_STAGES-1:0][17:0]  plain_sr;
  logic                          sdata_s;
  logic                          sel_s;
  logic [15:0]                   a_s;

  assign plain_d = {pi_sdata, pi_sel, ti_a};

  always_ff @(posedge clk) begin
    if (rst) plain_sr <= '0;
    else     plain_sr <= {plain_sr[SYNC_STAGES-2:0], plain_d};
  end

  assign sdata_s = plain_sr[SYNC_STAGES-1][17];
  assign sel_s   = plain_sr[SYNC_STAGES-1][16];
  assign a_s     = plain_sr[SYNC_STAGES-1][15:0];

  logic [SHIFT_W-1:0] shift_q;
  logic [3:0]         bit_cnt;
  logic [7:0]         frame_data;
  logic               par_ok;
  logic               frame_ok;

`ifdef TIPI_SHIFT_PARITY_EN
  assign frame_data = shift_q[8:1];
  assign par_ok     = ^shift_q;
`else
  assign frame_data = shift_q;
  assign par_ok     = 1'b1;
`endif

  assign frame_ok = (bit_cnt == FRAME_LEN) && par_ok;

  // Latch wins over a coincident sclk edge; that shift is dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      shift_q   <= '0;
      bit_cnt   <= '0;
      rd_q      <= '0;
      rc_q      <= '0;
      frame_err <= 1'b0;
    end else if (latch_rise) begin
      bit_cnt <= '0;
      if (frame_ok) begin
        if (sel_s == SEL_RC) rc_q <= frame_data;
        else                 rd_q <= frame_data;
      end else begin
        frame_err <= 1'b1;
      end
    end else if (sclk_rise) begin
      shift_q <= {shift_q[SHIFT_W-2:0], sdata_s};
      if (bit_cnt != 4'hF) bit_cnt <= bit_cnt + 4'd1;
    end
  end

  logic read_hit;

  assign read_hit = !memen_s && dbin_s &&
                    ((a_s == RD_ADDR) || (a_s == RC_ADDR));

  // Snapshot once at read start so a mid-read latch cannot glitch the bus.
  always_ff @(posedge clk) begin
    if (rst) begin
      ti_data_out <= '0;
      ti_data_oe  <= 1'b0;
    end else if (!read_hit) begin
      ti_data_oe <= 1'b0;
    end else if (!ti_data_oe) begin
      ti_data_oe  <= 1'b1;
      ti_data_out <= (a_s == RC_ADDR) ? rc_q : rd_q;
    end
  end

endmodule

// File: doc/tipi_pi_read_path.md
# tipi_pi_read_path

Pi-to-TI return path of the TIPI board: deserialises bytes shifted in by the Raspberry Pi and holds them in two read-back registers, RD (data) and RC (control). It answers TI-99/4A memory reads of 0x5FFB (RD) and 0x5FF9 (RC) by driving the TI data bus. It is the reader-side counterpart of the TI write latches at 0x5FFF/0x5FFD and sits beside them in the CPLD/FPGA top level.

## Interface
Parameters:
- SYNC_STAGES, 2, synchroniser depth for every asynchronous input, minimum 2.
- RD_ADDR, 16'h5FFB, TI address returning RD.
- RC_ADDR, 16'h5FF9, TI address returning RC.

Ports:
- clk  input  1  50 MHz system clock.
- rst  input  1  synchronous, active-high reset.
- pi_sclk  input  1  Pi shift clock, asynchronous; data is sampled on its rising edge.
- pi_sdata  input  1  Pi serial data, MSB first.
- pi_latch  input  1  Pi latch strobe, asynchronous; its rising edge ends a frame.
- pi_sel  input  1  target register for the frame: 0 = RD, 1 = RC. Sampled at the latch edge.
- ti_a  input  [0:15]  TI address bus; ti_a[0] is the MSB.
- ti_memen  input  1  TI memory enable, active low.
- ti_dbin  input  1  TI read strobe, active high.
- ti_data_out  output  [7:0]  read data to the TI bus.
- ti_data_oe  output  1  bus driver enable, active high.
- rd_q  output  [7:0]  current RD, for LEDs and debug.
- rc_q  output  [7:0]  current RC.
- frame_err  output  1  sticky flag for a malformed frame.

## Operation
- All asynchronous inputs pass through SYNC_STAGES flops, then a one-flop edge detector.
- Shift side:
  - Each synchronised pi_sclk rise shifts pi_sdata into shift_q LSB and increments bit_cnt.
  - bit_cnt is 4 bits and saturates at 15.
- Latch side, on a synchronised pi_latch rise:
  - If bit_cnt equals the frame length, shift_q[7:0] is copied to RD or RC according to pi_sel.
  - Otherwise nothing is copied and frame_err is set.
  - In both cases bit_cnt is cleared.
- If a latch rise and an sclk rise are detected in the same cycle, the latch is processed and that sclk edge is dropped.
- Bus side:
  - A read is active when synchronised ti_memen = 0, ti_dbin = 1, and ti_a equals RD_ADDR or RC_ADDR.
  - On the first cycle a read is active, the selected register is snapshotted into ti_data_out and ti_data_oe is set.
  - Both hold until the read is no longer active.
  - A latch landing during an active read does not change ti_data_out. The new value appears on the next read.
  - Reads of any other address leave ti_data_oe low.
- frame_err is cleared only by rst.
- Reset values: rd_q, rc_q, shift_q, bit_cnt and ti_data_out = 0; ti_data_oe = 0; frame_err = 0.
- Reset mid-frame discards the partial frame. Reset mid-read drops ti_data_oe on the next clk.

## Timing
- Pin to detected edge: SYNC_STAGES + 1 cycles (3 cycles = 60 ns at default).
- Latch edge detected to rd_q/rc_q updated: 1 cycle.
- TI read start to ti_data_oe high: SYNC_STAGES + 1 cycles. TI read end to ti_data_oe low: the same.
- The TI read cycle is ≥ 333 ns, so data is valid well before the TI samples it.
- The Pi must hold pi_sclk high and low for ≥ 4 clk cycles each.
- The Pi must hold pi_sel and pi_sdata stable ≥ 4 cycles around its strobe edges.

## Configuration
- TIPI_SHIFT_PARITY_EN defined:
  - Frame length is 9. The 9th bit shifted is odd parity over the 8 data bits.
  - A parity mismatch at latch time sets frame_err and discards the frame.
  - Data is shift_q[8:1].
- TIPI_SHIFT_PARITY_EN undefined: frame length is 8, no parity check, data is shift_q[7:0].

## Structure
- Package tipi_pkg holds:
  - the address constants 5FFF/5FFD/5FFB/5FF9;
  - the frame length constants;
  - the register select encoding (SEL_RD = 0, SEL_RC = 1).
- Sub-module tipi_sync: a parameterised SYNC_STAGES synchroniser with rise-detect output.
  - One instance each for pi_sclk, pi_latch, ti_memen and ti_dbin.
  - pi_sdata, pi_sel and ti_a use plain synchronisers.

## Test plan
- Reset, then shift 8'hA5 with pi_sel = 0 and latch -> rd_q = A5, rc_q = 00, frame_err = 0.
- Shift 8'h3C with pi_sel = 1 and latch, then TI read of 5FF9 -> ti_data_oe high within 3 cycles, ti_data_out = 3C; read of 5FFB -> ti_data_out = A5.
- Latch after only 5 bits -> no register change, frame_err = 1. The next full 8'h11 frame still loads.
- Start a TI read of 5FFB, then complete a frame of 8'h77 during the read -> ti_data_out stays A5 until the read ends; the next read returns 77.
- Read of 5FFE and a write cycle (ti_dbin = 0) to 5FFB -> ti_data_oe stays 0.
- With TIPI_SHIFT_PARITY_EN defined:
  - 8'h01 followed by parity 0 -> loads.
  - 8'h01 followed by parity 1 -> frame_err = 1 and the register is unchanged.
